branch_update_arbiter: RTL and testbench
========================================

BRANCH_UPDATE_ARBITER -- requirements
Module: branch_update_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: update FIFO entries; power of two, at least 2.
REQ-002 Parameter STARVE_LIMIT, default 8: number of consecutive blocked cycles before an update is forced; range 1..255.
REQ-003 iCLOCK  in  1  clock; all state changes on its rising edge.
REQ-004 inRESET  in  1  reset; asynchronous, active-low.
REQ-005 iFLUSH  in  1  pipeline flush request.
REQ-006 iUPD_REQ  in  1  execute stage presents a resolved branch.
REQ-007 iUPD_TAKEN  in  1  branch was taken.
REQ-008 iUPD_TARGET  in  32  resolved target address.
REQ-009 iUPD_INST_ADDR  in  32  address of the branch instruction.
REQ-010 oUPD_BUSY  out  1  update not accepted this cycle.
REQ-011 iFETCH_SEARCH  in  1  fetch needs the branch cache search port this cycle.
REQ-012 oFETCH_STALL  out  1  fetch search is denied this cycle.
REQ-013 oJUMP_STB, oJUMP_VALID  out  1 each  branch cache write strobe; taken flag.
REQ-014 oJUMP_ADDR, oJUMP_INST_ADDR  out  32 each  target address; branch instruction address.
REQ-015 oCACHE_FLUSH  out  1  branch cache flush pulse.
REQ-016 oPENDING  out  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 The block SHALL buffer updates in a FIFO of DEPTH entries. Each entry holds {taken, target[31:0], inst_addr[31:0]}.
REQ-018 oUPD_BUSY SHALL be 1 when the FIFO is full or when the state is FLUSH, and 0 otherwise.
REQ-019 An update SHALL be enqueued at the clock edge ending a cycle in which iUPD_REQ=1, oUPD_BUSY=0 and iFLUSH=0. Requests made while busy are dropped; no retry is implied.
REQ-020 oJUMP_VALID, oJUMP_ADDR and oJUMP_INST_ADDR SHALL combinationally present the FIFO head. They are all-zero when the FIFO is empty.
REQ-021 Grant rule: oJUMP_STB = (FIFO non-empty) and (state = PEND) and (iFETCH_SEARCH=0 or starve_cnt = STARVE_LIMIT).
REQ-022 oFETCH_STALL = oJUMP_STB and iFETCH_SEARCH. Fetch search therefore has priority except when starvation forces an update.
REQ-023 The head SHALL be popped at the clock edge ending every cycle in which oJUMP_STB=1. This gives exactly one write per entry.
REQ-024 Minimum latency: an update enqueued at edge N appears on oJUMP_STB in cycle N+1. There is no same-cycle bypass.
REQ-025 Simultaneous enqueue and pop with the FIFO not full SHALL leave the count unchanged and preserve order. When the FIFO is full, enqueue is refused even if a pop occurs in the same cycle.
REQ-026 starve_cnt, 8-bit, SHALL:
  - increment when the FIFO is non-empty and oJUMP_STB=0 because iFETCH_SEARCH=1;
  - saturate at STARVE_LIMIT;
  - clear on any pop, when the FIFO is empty, and on flush.
REQ-027 The state machine SHALL have three states:
  - IDLE: FIFO empty. Goes to PEND on enqueue.
  - PEND: FIFO non-empty. Goes to IDLE when the last entry pops with no enqueue in the same cycle.
  - FLUSH: exactly one cycle, then IDLE.
REQ-028 iFLUSH=1 in any state SHALL:
  - suppress oJUMP_STB and oFETCH_STALL in that cycle;
  - clear the FIFO pointers, occupancy and starve_cnt at that edge;
  - enter FLUSH.
REQ-029 In the FLUSH state, oCACHE_FLUSH SHALL be 1 and no enqueue or issue occurs. oCACHE_FLUSH SHALL be 0 in every other state.
REQ-030 iFLUSH asserted while in FLUSH SHALL re-enter FLUSH. The pulse is extended by one cycle per asserted cycle.
REQ-031 Pointers SHALL wrap modulo DEPTH. oPENDING SHALL equal the write count minus the read count.

Reset
REQ-032 While inRESET=0, all of the following SHALL hold:
  - state = IDLE;
  - pointers, occupancy and starve_cnt = 0;
  - FIFO storage = 0;
  - outputs: oJUMP_STB=0, oJUMP_VALID=0, oJUMP_ADDR=0, oJUMP_INST_ADDR=0, oFETCH_STALL=0, oCACHE_FLUSH=0, oUPD_BUSY=0, oPENDING=0.
REQ-033 Reset asserted mid-operation SHALL discard pending updates immediately, without completing any write.

Verification
REQ-034 Single update: iUPD_REQ with taken=1, target 0x1000, inst 0x2004; iFETCH_SEARCH=0 -> next cycle oJUMP_STB=1 with those values; oPENDING returns 1->0.
REQ-035 Fill: 5 back-to-back requests with iFETCH_SEARCH=1 -> first 4 accepted; oUPD_BUSY=1 on the 5th; oPENDING=4; entries later drain in order.
REQ-036 Starvation: 1 entry pending, iFETCH_SEARCH held at 1 -> oJUMP_STB=1 and oFETCH_STALL=1 exactly on the 9th blocked cycle (STARVE_LIMIT=8); starve_cnt then returns to 0.
REQ-037 Flush: 3 entries pending, iFLUSH for 1 cycle -> no oJUMP_STB that cycle; oCACHE_FLUSH=1 for the next cycle; oPENDING=0; oUPD_BUSY=1 during FLUSH.
REQ-038 Concurrent: FIFO holds 2 entries, enqueue and grant in the same cycle -> oPENDING stays 2; issue order matches enqueue order.
REQ-039 Reset mid-drain: inRESET low while oJUMP_STB=1 -> all outputs 0 asynchronously; after release, oPENDING=0 and state is IDLE.

Source files
------------

// File: rtl/branch_update_arbiter.sv
// Arbitrates resolved-branch updates into the branch cache write port against fetch searches,
// buffering updates in a small FIFO and forcing a write once fetch has starved it long enough.
module branch_update_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     iCLOCK,
    input  logic                     inRESET,
    input  logic                     iFLUSH,
    input  logic                     iUPD_REQ,
    input  logic                     iUPD_TAKEN,
    input  logic [31:0]              iUPD_TARGET,
    input  logic [31:0]              iUPD_INST_ADDR,
    output logic                     oUPD_BUSY,
    input  logic                     iFETCH_SEARCH,
    output logic                     oFETCH_STALL,
    output logic                     oJUMP_STB,
    output logic                     oJUMP_VALID,
    output logic [31:0]              oJUMP_ADDR,
    output logic [31:0]              oJUMP_INST_ADDR,
    output logic                     oCACHE_FLUSH,
    output logic [$clog2(DEPTH):0]   oPENDING
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_FLUSH} state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    starve_cnt;

    logic          taken_mem  [DEPTH];
    logic [31:0]   target_mem [DEPTH];
    logic [31:0]   inst_mem   [DEPTH];

    logic full;
    logic empty;
    logic busy;
    logic enq;
    logic stb;
    logic limit_hit;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign limit_hit = (starve_cnt == 8'(STARVE_LIMIT));
    assign busy      = full || (state == ST_FLUSH);
    assign enq       = iUPD_REQ && !busy && !iFLUSH;
    // Fetch owns the search port unless the pending update has waited STARVE_LIMIT cycles.
    assign stb       = !empty && (state == ST_PEND) && !iFLUSH && (!iFETCH_SEARCH || limit_hit);

    assign oUPD_BUSY       = busy;
    assign oJUMP_STB       = stb;
    assign oFETCH_STALL    = stb && iFETCH_SEARCH;
    assign oJUMP_VALID     = !empty && taken_mem[rd_ptr];
    assign oJUMP_ADDR      = empty ? 32'd0 : target_mem[rd_ptr];
    assign oJUMP_INST_ADDR = empty ? 32'd0 : inst_mem[rd_ptr];
    assign oCACHE_FLUSH    = (state == ST_FLUSH);
    assign oPENDING        = count;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                taken_mem[i]  <= 1'b0;
                target_mem[i] <= '0;
                inst_mem[i]   <= '0;
            end
        end else if (enq) begin
            taken_mem[wr_ptr]  <= iUPD_TAKEN;
            target_mem[wr_ptr] <= iUPD_TARGET;
            inst_mem[wr_ptr]   <= iUPD_INST_ADDR;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else if (iFLUSH) begin
            state      <= ST_FLUSH;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (stb) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !stb)
                count <= count + 1'b1;
            else if (stb && !enq)
                count <= count - 1'b1;

            if (stb || empty)
                starve_cnt <= '0;
            else if (iFETCH_SEARCH && !limit_hit)
                starve_cnt <= starve_cnt + 1'b1;

            case (state)
                ST_IDLE:  if (enq) state <= ST_PEND;
                ST_PEND:  if (stb && !enq && (count == (AW+1)'(1))) state <= ST_IDLE;
                ST_FLUSH: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_update_arbiter.sv
// Directed and randomized bench for branch_update_arbiter against a queue-based reference model.
module tb_branch_update_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, upd_req, upd_taken, fetch_search;
    logic [31:0] upd_target, upd_inst;
    logic        upd_busy, fetch_stall, jump_stb, jump_valid, cache_flush;
    logic [31:0] jump_addr, jump_inst;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered queue of {taken, target, inst}, a flush-in-progress flag
    // and a count of consecutive cycles the head was refused the port.
    logic [64:0] q[$];
    bit          flushing;
    int          starve;
    logic        obs_stb;

    always #5 clk = ~clk;

    branch_update_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .iCLOCK(clk), .inRESET(rst_n), .iFLUSH(flush),
        .iUPD_REQ(upd_req), .iUPD_TAKEN(upd_taken), .iUPD_TARGET(upd_target),
        .iUPD_INST_ADDR(upd_inst), .oUPD_BUSY(upd_busy), .iFETCH_SEARCH(fetch_search),
        .oFETCH_STALL(fetch_stall), .oJUMP_STB(jump_stb), .oJUMP_VALID(jump_valid),
        .oJUMP_ADDR(jump_addr), .oJUMP_INST_ADDR(jump_inst), .oCACHE_FLUSH(cache_flush),
        .oPENDING(pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stb"},   32'(jump_stb),    0);
        chk({tag, "_valid"}, 32'(jump_valid),  0);
        chk({tag, "_addr"},  jump_addr,        0);
        chk({tag, "_inst"},  jump_inst,        0);
        chk({tag, "_stall"}, 32'(fetch_stall), 0);
        chk({tag, "_cflush"},32'(cache_flush), 0);
        chk({tag, "_busy"},  32'(upd_busy),    0);
        chk({tag, "_pend"},  32'(pending),     0);
    endtask

    // One clock cycle: drive inputs, compare combinational outputs with the model, then advance.
    task automatic cycle(input bit req, input bit taken, input logic [31:0] tgt,
                         input logic [31:0] inst, input bit search, input bit fl);
        bit          e_busy, e_stb, e_enq, was_empty;
        logic [64:0] head;
        upd_req = req; upd_taken = taken; upd_target = tgt; upd_inst = inst;
        fetch_search = search; flush = fl;
        #2;
        e_busy = (q.size() == DEPTH) || flushing;
        e_stb  = (q.size() != 0) && !flushing && !fl && (!search || starve == LIMIT);
        e_enq  = req && !e_busy && !fl;
        head   = (q.size() != 0) ? q[0] : 65'd0;
        chk("busy",   32'(upd_busy),    32'(e_busy));
        chk("stb",    32'(jump_stb),    32'(e_stb));
        chk("stall",  32'(fetch_stall), 32'(e_stb && search));
        chk("valid",  32'(jump_valid),  32'(head[64]));
        chk("addr",   jump_addr,        head[63:32]);
        chk("inst",   jump_inst,        head[31:0]);
        chk("cflush", 32'(cache_flush), 32'(flushing));
        chk("pend",   32'(pending),     q.size());
        obs_stb = jump_stb;
        @(posedge clk);
        #1;
        was_empty = (q.size() == 0);
        if (fl) begin
            q.delete();
            starve   = 0;
            flushing = 1;
        end else begin
            flushing = 0;
            if (e_stb) void'(q.pop_front());
            if (e_enq) q.push_back({taken, tgt, inst});
            if (e_stb || was_empty) starve = 0;
            else if (search && starve < LIMIT) starve++;
        end
    endtask

    task automatic idle(input bit search);
        cycle(0, 0, 0, 0, search, 0);
    endtask

    initial begin
        int first_grant;
        rst_n = 1'b0; flush = 0; upd_req = 0; upd_taken = 0; upd_target = 0; upd_inst = 0;
        fetch_search = 0;
        flushing = 0; starve = 0;
        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(0);

        // Single update with fetch idle: issued the cycle after enqueue.
        cycle(1, 1, 32'h1000, 32'h2004, 0, 0);
        chk("single_pend1", 32'(pending), 1);
        upd_req = 0; fetch_search = 0; #2;
        chk("single_stb",  32'(jump_stb), 1);
        chk("single_addr", jump_addr, 32'h1000);
        chk("single_inst", jump_inst, 32'h2004);
        idle(0);
        chk("single_pend0", 32'(pending), 0);

        // Fill under fetch pressure: fifth request refused.
        for (int i = 0; i < 4; i++) cycle(1, i[0], 32'h100 + i, 32'h200 + i, 1, 0);
        chk("fill_pend", 32'(pending), 4);
        #0; upd_req = 1; fetch_search = 1; #2;
        chk("fill_busy5", 32'(upd_busy), 1);
        cycle(1, 1, 32'hDEAD, 32'hBEEF, 1, 0);
        upd_req = 0; fetch_search = 0; #2;
        chk("drain_first", jump_addr, 32'h100);
        for (int i = 0; i < 5; i++) idle(0);
        chk("drain_pend", 32'(pending), 0);

        // Starvation: grant forced on the ninth blocked cycle.
        cycle(1, 1, 32'h5555, 32'h6666, 1, 0);
        first_grant = 0;
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            if (obs_stb && first_grant == 0) first_grant = i;
        end
        chk("starve_cycle", first_grant, 9);
        chk("starve_pend",  32'(pending), 0);

        // Flush with three pending entries.
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h3000 + i, 32'h4000 + i, 1, 0);
        cycle(0, 0, 0, 0, 0, 1);
        chk("flush_cflush", 32'(cache_flush), 1);
        chk("flush_pend",   32'(pending), 0);
        chk("flush_busy",   32'(upd_busy), 1);
        cycle(1, 1, 32'h7777, 32'h8888, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        idle(0);
        idle(0);

        // Concurrent enqueue and grant at occupancy two.
        cycle(1, 0, 32'hA0, 32'hB0, 1, 0);
        cycle(1, 1, 32'hA1, 32'hB1, 1, 0);
        cycle(1, 0, 32'hA2, 32'hB2, 0, 0);
        chk("conc_pend", 32'(pending), 2);
        for (int i = 0; i < 3; i++) idle(0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++)
            cycle($urandom_range(0, 9) < 7, 1'($urandom), $urandom, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0);
        for (int i = 0; i < 12; i++) idle(0);

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'hC0 + i, 32'hD0 + i, 1, 0);
        upd_req = 0; fetch_search = 0; flush = 0; #2;
        chk("rstmid_stb", 32'(jump_stb), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rstmid");
        q.delete(); starve = 0; flushing = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(0);
        chk("rstmid_pend_after", 32'(pending), 0);
        cycle(1, 0, 32'hE0, 32'hF0, 0, 0);
        idle(0);
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
